// File: rtl/ldlt_factor_rx_pkg.sv
// ---------------------------------------------------------------------------
// ldlt_factor_rx_pkg
// Shared definitions for the LDLT factor receive path and the substitution
// stage that reuses the triangular index walker.
//   D_ADDR_W      : width of the row/column indices and the D memory address
//   rx_state_e    : receiver frame state (IDLE / RECV / DONE)
//   mat_order()   : matrix order N = 6*NODE_NUM (six DOF per node)
//   l_depth()     : packed strictly-lower depth N*(N-1)/2
// ---------------------------------------------------------------------------
package ldlt_factor_rx_pkg;

    localparam int D_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    function automatic int mat_order(input int node_num);
        return 6 * node_num;
    endfunction

    function automatic int l_depth(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/ldlt_factor_rx_tri_index.sv
// ---------------------------------------------------------------------------
// ldlt_tri_index
// Walks the lower triangle of an N x N matrix in column-major order
// (j = 0..N-1, i = j..N-1) and keeps a running packed address for the
// strictly-lower entries, so consumers never multiply to find an address.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the walk at (0,0), packed address 0
//   advance   : step to the next element of the triangle
//   i, j      : current row / column
//   laddr     : packed address of the current element if it is strictly lower
//   is_diag   : current element is on the diagonal
//   last      : current element is (N-1, N-1)
// ---------------------------------------------------------------------------
module ldlt_tri_index
    import ldlt_factor_rx_pkg::*;
#(
    parameter int N        = 600,
    parameter int ADDR_LEN = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    output logic [D_ADDR_W-1:0] i,
    output logic [D_ADDR_W-1:0] j,
    output logic [ADDR_LEN-1:0] laddr,
    output logic                is_diag,
    output logic                last
);

    localparam logic [D_ADDR_W-1:0] LAST_IDX = D_ADDR_W'(N - 1);

    logic [D_ADDR_W-1:0] i_q, i_d;
    logic [D_ADDR_W-1:0] j_q, j_d;
    logic [ADDR_LEN-1:0] laddr_q, laddr_d;

    assign is_diag = (i_q == j_q);
    assign last    = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        i_d     = i_q;
        j_d     = j_q;
        laddr_d = laddr_q;
        if (clear) begin
            i_d     = '0;
            j_d     = '0;
            laddr_d = '0;
        end else if (advance) begin
            // Strictly-lower entries are numbered consecutively in walk order.
            if (!is_diag) begin
                laddr_d = laddr_q + 1'b1;
            end
            // Bottom of a column: next column starts on its own diagonal.
            if (i_q == LAST_IDX) begin
                j_d = j_q + 1'b1;
                i_d = j_q + 1'b1;
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample together.
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            laddr_q <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            laddr_q <= laddr_d;
        end
    end

    assign i     = i_q;
    assign j     = j_q;
    assign laddr = laddr_q;

endmodule

// File: rtl/ldlt_factor_rx.sv
// ---------------------------------------------------------------------------
// ldlt_factor_rx
// Receives the LDLT engine's factor stream (lower triangle, column-major) and
// steers diagonal words to the external D memory and strictly-lower words to
// the external packed L memory. Raises sticky health flags for a
// non-positive pivot and for stream words arriving outside a frame.
//   clk, rst                     : clock, synchronous active-high reset
//   i_start                      : arm reception of one frame (honoured in IDLE)
//   i_valid, i_data              : factor word stream
//   o_l_wen, o_l_addr, o_l_data  : L memory write port
//   o_d_wen, o_d_addr, o_d_data  : D memory write port (address = column j)
//   o_busy                       : frame reception in progress
//   o_done                       : one-cycle pulse with the final D write
//   o_not_pd                     : sticky, some pivot D_jj <= 0
//   o_overrun                    : sticky, i_valid seen outside a frame
// All outputs are registered; an accepted word is written one cycle later.
// ---------------------------------------------------------------------------
module ldlt_factor_rx
    import ldlt_factor_rx_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int NODE_NUM = 100,
    parameter int FRACTION = 16,
    parameter int ADDR_LEN = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_valid,
    input  logic [DATA_LEN-1:0] i_data,
    output logic                o_l_wen,
    output logic [ADDR_LEN-1:0] o_l_addr,
    output logic [DATA_LEN-1:0] o_l_data,
    output logic                o_d_wen,
    output logic [D_ADDR_W-1:0] o_d_addr,
    output logic [DATA_LEN-1:0] o_d_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_not_pd,
    output logic                o_overrun
);

    localparam int N = mat_order(NODE_NUM);

    rx_state_e state_q, state_d;

    logic                l_wen_q, l_wen_d;
    logic [ADDR_LEN-1:0] l_addr_q, l_addr_d;
    logic [DATA_LEN-1:0] l_data_q, l_data_d;
    logic                d_wen_q, d_wen_d;
    logic [D_ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [DATA_LEN-1:0] d_data_q, d_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                not_pd_q, not_pd_d;
    logic                overrun_q, overrun_d;

    logic                start_ok;
    logic                accept;
    logic                non_pos;
    logic [D_ADDR_W-1:0] idx_i;
    logic [D_ADDR_W-1:0] idx_j;
    logic [ADDR_LEN-1:0] idx_laddr;
    logic                idx_diag;
    logic                idx_last;

    assign start_ok = i_start && (state_q == ST_IDLE);
    assign accept   = i_valid && (state_q == ST_RECV);

    // Value <= 0: negative, or both integer and fraction fields are zero.
    assign non_pos = i_data[DATA_LEN-1]
                   | ((~|i_data[DATA_LEN-1:FRACTION]) & (~|i_data[FRACTION-1:0]));

    ldlt_tri_index #(
        .N        (N),
        .ADDR_LEN (ADDR_LEN)
    ) u_tri_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .advance (accept),
        .i       (idx_i),
        .j       (idx_j),
        .laddr   (idx_laddr),
        .is_diag (idx_diag),
        .last    (idx_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start)             state_d = ST_RECV;
            ST_RECV: if (accept && idx_last)  state_d = ST_DONE;
            ST_DONE:                          state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        l_wen_d   = accept && !idx_diag;
        d_wen_d   = accept &&  idx_diag;
        // Address/data hold their last written values between strobes.
        l_addr_d  = l_wen_d ? idx_laddr : l_addr_q;
        l_data_d  = l_wen_d ? i_data    : l_data_q;
        d_addr_d  = d_wen_d ? idx_j     : d_addr_q;
        d_data_d  = d_wen_d ? i_data    : d_data_q;
        done_d    = accept && idx_last;
        busy_d    = (state_d == ST_RECV);

        // A fresh frame clears the sticky flags; a same-cycle event re-sets them.
        not_pd_d  = start_ok ? 1'b0 : not_pd_q;
        overrun_d = start_ok ? 1'b0 : overrun_q;
        if (d_wen_d && non_pos) begin
            not_pd_d = 1'b1;
        end
        if (i_valid && (state_q != ST_RECV)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            l_wen_q   <= 1'b0;
            l_addr_q  <= '0;
            l_data_q  <= '0;
            d_wen_q   <= 1'b0;
            d_addr_q  <= '0;
            d_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            not_pd_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_wen_q   <= l_wen_d;
            l_addr_q  <= l_addr_d;
            l_data_q  <= l_data_d;
            d_wen_q   <= d_wen_d;
            d_addr_q  <= d_addr_d;
            d_data_q  <= d_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            not_pd_q  <= not_pd_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_l_wen   = l_wen_q;
    assign o_l_addr  = l_addr_q;
    assign o_l_data  = l_data_q;
    assign o_d_wen   = d_wen_q;
    assign o_d_addr  = d_addr_q;
    assign o_d_data  = d_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_not_pd  = not_pd_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_ldlt_factor_rx.sv
// ---------------------------------------------------------------------------
// tb_ldlt_factor_rx
// Directed bench for ldlt_factor_rx with NODE_NUM=1 (N=6, 21 words/frame).
// A negedge monitor logs every write against the expected D/L tables; the
// scenario tasks drive frames and compare the logged results inline.
// ---------------------------------------------------------------------------
module tb_ldlt_factor_rx;

    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 4;
    localparam int NWORDS   = 21;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_start = 1'b0;
    logic                i_valid = 1'b0;
    logic [DATA_LEN-1:0] i_data = '0;
    logic                o_l_wen;
    logic [ADDR_LEN-1:0] o_l_addr;
    logic [DATA_LEN-1:0] o_l_data;
    logic                o_d_wen;
    logic [9:0]          o_d_addr;
    logic [DATA_LEN-1:0] o_d_data;
    logic                o_busy;
    logic                o_done;
    logic                o_not_pd;
    logic                o_overrun;

    ldlt_factor_rx #(
        .DATA_LEN (DATA_LEN),
        .NODE_NUM (1),
        .FRACTION (16),
        .ADDR_LEN (ADDR_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_l_wen   (o_l_wen),
        .o_l_addr  (o_l_addr),
        .o_l_data  (o_l_data),
        .o_d_wen   (o_d_wen),
        .o_d_addr  (o_d_addr),
        .o_d_data  (o_d_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_not_pd  (o_not_pd),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Stimulus words (index 1..21) and expected memory contents.
    logic signed [DATA_LEN-1:0] word_val [NWORDS+1];
    logic signed [DATA_LEN-1:0] exp_d [6];
    logic signed [DATA_LEN-1:0] exp_l [15];

    // Monitor log.
    int d_cnt, l_cnt, d_bad, l_bad, dual, done_cnt, done_bad, busy_low;
    bit np_at_d [6];

    always @(negedge clk) begin
        if (o_d_wen === 1'b1) begin
            if (d_cnt < 6) begin
                if (o_d_addr !== 10'(d_cnt) || o_d_data !== exp_d[d_cnt]) d_bad++;
                np_at_d[d_cnt] = o_not_pd;
            end else begin
                d_bad++;
            end
            d_cnt++;
        end
        if (o_l_wen === 1'b1) begin
            if (l_cnt >= 15 || o_l_addr !== ADDR_LEN'(l_cnt) || o_l_data !== exp_l[l_cnt]) l_bad++;
            l_cnt++;
        end
        if (o_d_wen === 1'b1 && o_l_wen === 1'b1) dual++;
        if (o_done === 1'b1) begin
            done_cnt++;
            if (!(o_d_wen === 1'b1 && o_d_addr === 10'd5)) done_bad++;
        end
    end

    task automatic set_defaults();
        for (int w = 0; w <= NWORDS; w++) word_val[w] = DATA_LEN'(w);
        exp_d = '{32'sd1, 32'sd7, 32'sd12, 32'sd16, 32'sd19, 32'sd21};
        exp_l = '{32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd8, 32'sd9, 32'sd10,
                  32'sd11, 32'sd13, 32'sd14, 32'sd15, 32'sd17, 32'sd18, 32'sd20};
    endtask

    task automatic clear_log();
        d_cnt = 0; l_cnt = 0; d_bad = 0; l_bad = 0; dual = 0;
        done_cnt = 0; done_bad = 0; busy_low = 0;
        for (int k = 0; k < 6; k++) np_at_d[k] = 1'b0;
    endtask

    // One cycle: apply inputs at negedge, DUT samples at the next posedge.
    task automatic drive(input bit v, input bit s, input logic [DATA_LEN-1:0] d);
        i_valid = v;
        i_start = s;
        i_data  = d;
        @(negedge clk);
    endtask

    // Words first..last; optional gap every third cycle; optional i_start
    // alongside word start_at. Busy must stay high until the last word lands.
    task automatic send_words(input int first, input int last, input bit gaps, input int start_at);
        int cyc = 0;
        for (int w = first; w <= last; w++) begin
            cyc++;
            if (gaps && (cyc % 3 == 0)) begin
                drive(1'b0, 1'b0, 32'hDEAD_BEEF);
                if (o_busy !== 1'b1) busy_low++;
                cyc++;
            end
            drive(1'b1, (w == start_at), word_val[w]);
            if (w < NWORDS && o_busy !== 1'b1) busy_low++;
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input bit gaps);
        drive(1'b0, 1'b1, '0);
        send_words(1, NWORDS, gaps, 0);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 8; k++) begin
            #1;
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (done_cnt === 0) begin
            tests_failed++;
            $display("FAIL done_timeout: o_done never pulsed within budget");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_l_wen, o_l_addr, o_l_data, o_d_wen, o_d_addr, o_d_data,
             o_busy, o_done, o_not_pd, o_overrun} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got l_wen=%b d_wen=%b busy=%b done=%b np=%b ovr=%b, want all 0",
                     o_l_wen, o_d_wen, o_busy, o_done, o_not_pd, o_overrun);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        tests_run++;
        if (d_cnt !== 6 || d_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s_d_writes: got %0d writes %0d bad, want 6 writes 0 bad", tag, d_cnt, d_bad);
        end
        tests_run++;
        if (l_cnt !== 15 || l_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s_l_writes: got %0d writes %0d bad, want 15 writes 0 bad", tag, l_cnt, l_bad);
        end
        tests_run++;
        if (done_cnt !== 1 || done_bad !== 0 || dual !== 0) begin
            tests_failed++;
            $display("FAIL %s_done: got done=%0d misaligned=%0d dual=%0d, want 1/0/0", tag, done_cnt, done_bad, dual);
        end
    endtask

    task automatic test_contiguous();
        set_defaults();
        clear_log();
        send_frame(1'b0);
        wait_done();
        check_frame("contig");
        tests_run++;
        if (o_not_pd !== 1'b0 || o_overrun !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL contig_flags: got np=%b ovr=%b busy=%b, want 0/0/0", o_not_pd, o_overrun, o_busy);
        end
        tests_run++;
        if (o_d_addr !== 10'd5 || o_d_data !== 32'd21 || o_l_addr !== 4'd14 || o_l_data !== 32'd20) begin
            tests_failed++;
            $display("FAIL contig_hold: got d=%0d/%0d l=%0d/%0d, want d=5/21 l=14/20",
                     o_d_addr, o_d_data, o_l_addr, o_l_data);
        end
    endtask

    task automatic test_gaps();
        set_defaults();
        clear_log();
        send_frame(1'b1);
        wait_done();
        check_frame("gaps");
        tests_run++;
        if (busy_low !== 0) begin
            tests_failed++;
            $display("FAIL gaps_busy: got %0d cycles with busy low mid-frame, want 0", busy_low);
        end
    endtask

    task automatic test_not_pd();
        set_defaults();
        word_val[12] = 32'sd0;
        word_val[19] = -32'sd5;
        exp_d[2] = 32'sd0;
        exp_d[4] = -32'sd5;
        clear_log();
        send_frame(1'b0);
        wait_done();
        check_frame("notpd");
        tests_run++;
        if (np_at_d[1] !== 1'b0 || np_at_d[2] !== 1'b1 || np_at_d[5] !== 1'b1 || o_not_pd !== 1'b1) begin
            tests_failed++;
            $display("FAIL notpd_timing: got at_d1=%b at_d2=%b at_d5=%b end=%b, want 0/1/1/1",
                     np_at_d[1], np_at_d[2], np_at_d[5], o_not_pd);
        end
        set_defaults();
        clear_log();
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (o_not_pd !== 1'b0) begin
            tests_failed++;
            $display("FAIL notpd_clear: got %b after i_start, want 0", o_not_pd);
        end
        send_words(1, NWORDS, 1'b0, 0);
        wait_done();
        check_frame("notpd_next");
    endtask

    task automatic test_overrun();
        set_defaults();
        clear_log();
        drive(1'b1, 1'b0, 32'd77);
        drive(1'b0, 1'b0, '0);
        tests_run++;
        if (o_overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_idle: got %b, want 1", o_overrun);
        end
        // i_start with i_valid: the word is dropped and still flags overrun.
        drive(1'b1, 1'b1, 32'd99);
        tests_run++;
        if (o_overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_start: got %b, want 1", o_overrun);
        end
        send_words(1, NWORDS, 1'b0, 0);
        wait_done();
        check_frame("overrun");
    endtask

    task automatic test_reset_mid();
        set_defaults();
        clear_log();
        drive(1'b0, 1'b1, '0);
        for (int w = 1; w <= 10; w++) drive(1'b1, 1'b0, word_val[w]);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        rst = 1'b0;
        tests_run++;
        if ({o_l_wen, o_l_addr, o_l_data, o_d_wen, o_d_addr, o_d_data,
             o_busy, o_done, o_not_pd, o_overrun} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got l_addr=%0d d_addr=%0d busy=%b, want all 0", o_l_addr, o_d_addr, o_busy);
        end
        drive(1'b1, 1'b0, 32'd55);
        #1;
        clear_log();
        tests_run++;
        if (o_l_wen !== 1'b0 || o_d_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_nowrite: got l_wen=%b d_wen=%b after reset, want 0/0", o_l_wen, o_d_wen);
        end
        send_frame(1'b0);
        wait_done();
        check_frame("rstmid");
    endtask

    task automatic test_start_mid();
        set_defaults();
        clear_log();
        drive(1'b0, 1'b1, '0);
        send_words(1, NWORDS, 1'b0, 11);
        wait_done();
        check_frame("startmid");
    endtask

    initial begin
        set_defaults();
        clear_log();
        @(negedge clk);
        test_reset();
        test_contiguous();
        test_gaps();
        test_not_pd();
        test_overrun();
        test_reset_mid();
        test_start_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
